// File: rtl/hub75_frame_driver_if.sv
// hub75_frame_driver_if
//   Pixel write port and buffer-swap handshake between the SPI receive logic
//   (master) and hub75_frame_driver (slave).
//   Parameters: AW = write address width ({y, x}), DW = pixel width ({r, g, b}).
//   Signals:
//     wr_en         master->slave  pixel write strobe
//     wr_addr       master->slave  {y, x}; y MSB selects bottom half
//     wr_data       master->slave  {r, g, b}
//     swap_req      master->slave  request a bank swap at the next frame end
//     swap_pending  slave->master  swap requested but not yet performed
interface hub75_frame_driver_if #(
  parameter int AW = 10,
  parameter int DW = 6
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_pending;

  modport master (output wr_en, wr_addr, wr_data, swap_req, input swap_pending);
  modport slave  (input wr_en, wr_addr, wr_data, swap_req, output swap_pending);
endinterface

// File: rtl/hub75_frame_driver.sv
// hub75_frame_driver
//   Self-timed HUB75 panel driver with an internal pixel frame buffer and
//   binary-coded modulation. Each (row, plane) runs
//   PREFETCH -> SHIFT (2*COLS) -> BLANK -> LATCH -> DISPLAY (BASE_ON << plane).
//   Optional double buffering is enabled by defining HUB75_DBUF_EN; without it
//   a single bank is both written and displayed and swap requests are ignored.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   bus (slave)       pixel write port and swap handshake
//   o_rgb1 / o_rgb2   top / bottom half colour bits of the current plane
//   o_row_addr        latched row-pair select
//   o_sclk, o_lat     panel shift clock and latch
//   o_oe_n            panel output enable, active-low
//   o_frame_done      one-cycle pulse on the last cycle of each frame
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_PREFETCH | read column 0 of current row (top and bottom half)
// S_SHIFT    | phase 0: sclk low, data valid; phase 1: sclk high, next read
// S_BLANK    | outputs off ahead of the latch
// S_LATCH    | lat high, row address updated to the shifted row
// S_DISPLAY  | outputs on for BASE_ON << plane cycles (down-counter)
module hub75_frame_driver #(
  parameter int COLS       = 32,
  parameter int ROW_ADDR_W = 4,
  parameter int BPC        = 2,
  parameter int BASE_ON    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  hub75_frame_driver_if.slave   bus,
  output logic [2:0]            o_rgb1,
  output logic [2:0]            o_rgb2,
  output logic [ROW_ADDR_W-1:0] o_row_addr,
  output logic                  o_sclk,
  output logic                  o_lat,
  output logic                  o_oe_n,
  output logic                  o_frame_done
);
  localparam int CW  = $clog2(COLS);
  localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DCW = $clog2((BASE_ON << (BPC - 1)) + 1);
  localparam int DW  = 3 * BPC;
  localparam int HW  = ROW_ADDR_W + CW;
  localparam int AW  = HW + 1;

  localparam logic [2:0] S_PREFETCH = 3'd0;
  localparam logic [2:0] S_SHIFT    = 3'd1;
  localparam logic [2:0] S_BLANK    = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_DISPLAY  = 3'd4;

  logic [2:0]            r_state;
  logic [CW-1:0]         r_col;
  logic                  r_phase;
  logic [ROW_ADDR_W-1:0] r_row;
  logic [PW-1:0]         r_plane;
  logic [DCW-1:0]        r_disp_cnt;
  logic                  r_first;
  logic [ROW_ADDR_W-1:0] r_row_addr;
  logic [DW-1:0]         r_pix_top;
  logic [DW-1:0]         r_pix_bot;

  logic                  w_col_last;
  logic                  w_plane_last;
  logic                  w_row_last;
  logic                  w_disp_tc;
  logic                  w_frame_end;
  logic                  w_rd_en;
  logic [CW-1:0]         w_rd_col;
  logic [DCW-1:0]        w_disp_load;

  assign w_col_last   = (r_col == CW'(COLS - 1));
  assign w_plane_last = (r_plane == PW'(BPC - 1));
  assign w_row_last   = (r_row == '1);
  assign w_disp_tc    = (r_disp_cnt == '0);
  assign w_frame_end  = (r_state == S_DISPLAY) && w_disp_tc && w_row_last && w_plane_last;
  assign w_disp_load  = DCW'((BASE_ON << r_plane) - 1);

  // Reads: column 0 in PREFETCH, the following column during each sclk-high
  // phase. No read after the last column so the data register holds still.
  assign w_rd_en  = (r_state == S_PREFETCH) ||
                    ((r_state == S_SHIFT) && r_phase && !w_col_last);
  assign w_rd_col = (r_state == S_PREFETCH) ? '0 : r_col + 1'b1;

`ifdef HUB75_DBUF_EN
  localparam int MW = HW + 1;
  logic r_front;
  logic r_swap_pending;

  // A request arriving in the frame_done cycle is honoured at that boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_frame_end) begin
      r_swap_pending <= 1'b0;
      if (r_swap_pending || bus.swap_req) r_front <= ~r_front;
    end else if (bus.swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  assign bus.swap_pending = r_swap_pending;

  logic [MW-1:0] w_wr_idx;
  logic [MW-1:0] w_rd_idx;
  assign w_wr_idx = {~r_front, bus.wr_addr[HW-1:0]};
  assign w_rd_idx = {r_front, r_row, w_rd_col};
`else
  localparam int MW = HW;
  logic w_unused_swap;
  assign w_unused_swap    = bus.swap_req;
  assign bus.swap_pending = 1'b0;

  logic [MW-1:0] w_wr_idx;
  logic [MW-1:0] w_rd_idx;
  assign w_wr_idx = bus.wr_addr[HW-1:0];
  assign w_rd_idx = {r_row, w_rd_col};
`endif

  // Top and bottom halves live in separate arrays so both are read together.
  logic [DW-1:0] r_mem_top [2**MW];
  logic [DW-1:0] r_mem_bot [2**MW];

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      if (bus.wr_addr[AW-1]) r_mem_bot[w_wr_idx] <= bus.wr_data;
      else                   r_mem_top[w_wr_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_top <= '0;
      r_pix_bot <= '0;
    end else if (w_rd_en) begin
      r_pix_top <= r_mem_top[w_rd_idx];
      r_pix_bot <= r_mem_bot[w_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_PREFETCH;
      r_col      <= '0;
      r_phase    <= 1'b0;
      r_row      <= '0;
      r_plane    <= '0;
      r_disp_cnt <= '0;
      r_first    <= 1'b1;
      r_row_addr <= '0;
    end else begin
      case (r_state)
        S_PREFETCH: begin
          r_state <= S_SHIFT;
          r_col   <= '0;
          r_phase <= 1'b0;
        end
        S_SHIFT: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (w_col_last) r_state <= S_BLANK;
            else            r_col   <= r_col + 1'b1;
          end
        end
        S_BLANK: begin
          r_state    <= S_LATCH;
          r_row_addr <= r_row;
        end
        S_LATCH: begin
          r_state    <= S_DISPLAY;
          r_first    <= 1'b0;
          r_disp_cnt <= w_disp_load;
        end
        S_DISPLAY: begin
          if (w_disp_tc) begin
            r_state <= S_PREFETCH;
            if (w_plane_last) begin
              r_plane <= '0;
              r_row   <= r_row + 1'b1;
            end else begin
              r_plane <= r_plane + 1'b1;
            end
          end else begin
            r_disp_cnt <= r_disp_cnt - 1'b1;
          end
        end
        default: r_state <= S_PREFETCH;
      endcase
    end
  end

  // The previous plane keeps displaying while the next one shifts in, except
  // right after reset when nothing valid has been latched yet.
  assign o_sclk       = (r_state == S_SHIFT) && r_phase;
  assign o_lat        = (r_state == S_LATCH);
  assign o_oe_n       = (r_state == S_BLANK) || (r_state == S_LATCH) ||
                        (((r_state == S_PREFETCH) || (r_state == S_SHIFT)) && r_first);
  assign o_row_addr   = r_row_addr;
  assign o_frame_done = w_frame_end;

  always_comb begin
    o_rgb1 = 3'b000;
    o_rgb2 = 3'b000;
    for (int b = 0; b < BPC; b++) begin
      if (r_plane == PW'(b)) begin
        o_rgb1 = {r_pix_top[2*BPC+b], r_pix_top[BPC+b], r_pix_top[b]};
        o_rgb2 = {r_pix_bot[2*BPC+b], r_pix_bot[BPC+b], r_pix_bot[b]};
      end
    end
  end
endmodule
